// File: rtl/simd_left_shifter_pipe.sv
// Two-stage SIMD left shifter for posit field extraction: each lane group is shifted left by
// its count+1 with no bits crossing group boundaries; valid/ready on both sides.
module simd_left_shifter_pipe #(
    parameter int WIDTH    = 32,
    parameter int LANE_MIN = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [1:0]                                 in_mode,
    input  logic [WIDTH-1:0]                           in_data,
    input  logic [(WIDTH/LANE_MIN)*$clog2(WIDTH)-1:0]  in_cnt,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WIDTH-1:0]                           out_data,
    output logic [WIDTH/LANE_MIN-1:0]                  out_zero,
    output logic                                       out_err
);

    localparam int NLANES = WIDTH / LANE_MIN;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int MAXM   = $clog2(NLANES);
    localparam int SH_W   = CNT_W + 1;
    localparam int FINE_W = 2;

    // Handshake: a beat moves on a rising edge where valid && ready; valid never waits on ready,
    // in_ready is combinational from out_ready so a full pipe still accepts while draining.

    // Shift every group of width LANE_MIN<<m left by the amount held in its lowest sub-lane.
    function automatic logic [WIDTH-1:0] grp_shift(input logic [WIDTH-1:0]       d,
                                                   input logic [1:0]             m,
                                                   input logic [NLANES*SH_W-1:0] amt);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] gmask;
        logic [WIDTH-1:0] grp;
        logic [SH_W-1:0]  a;
        int               lo;
        r     = '0;
        gmask = {WIDTH{1'b1}} >> (WIDTH - (LANE_MIN << m));
        for (int g = 0; g < NLANES; g++) begin
            if ((g & ((1 << m) - 1)) == 0) begin
                lo  = g * LANE_MIN;
                a   = amt[g*SH_W +: SH_W];
                grp = (d >> lo) & gmask;
                r   = r | (((grp << a) & gmask) << lo);
            end
        end
        return r;
    endfunction

    logic                      s1_valid_q;
    logic [WIDTH-1:0]          s1_data_q,  s1_data_d;
    logic [1:0]                s1_mode_q,  s1_mode_d;
    logic [NLANES-1:0]         s1_zero_q,  s1_zero_d;
    logic [NLANES*FINE_W-1:0]  s1_fine_q,  s1_fine_d;
    logic                      s1_err_q,   s1_err_d;
    logic [NLANES*SH_W-1:0]    coarse_amt;

    logic                      out_valid_q;
    logic [WIDTH-1:0]          out_data_q, out_data_d;
    logic [NLANES-1:0]         out_zero_q;
    logic                      out_err_q;
    logic [NLANES*SH_W-1:0]    fine_amt;
    logic [WIDTH-1:0]          s2_shift;

    logic                      s2_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // S1: decode mode, broadcast each group's count, coarse shift by multiples of 4.
    always_comb begin
        s1_err_d   = (int'(in_mode) > MAXM);
        s1_mode_d  = s1_err_d ? 2'd0 : in_mode;
        s1_zero_d  = '0;
        s1_fine_d  = '0;
        coarse_amt = '0;
        for (int j = 0; j < NLANES; j++) begin
            int              lo;
            logic [SH_W-1:0] s;
            lo = j & ~((1 << s1_mode_d) - 1);
            s  = {1'b0, in_cnt[lo*CNT_W +: CNT_W]} + SH_W'(1);
            if (!s1_err_d && (int'(s) >= (LANE_MIN << s1_mode_d))) begin
                s1_zero_d[j] = 1'b1;
            end else begin
                coarse_amt[j*SH_W +: SH_W]   = {s[SH_W-1:FINE_W], {FINE_W{1'b0}}};
                s1_fine_d[j*FINE_W +: FINE_W] = s[FINE_W-1:0];
            end
        end
        s1_data_d = grp_shift(in_data, s1_mode_d, coarse_amt);
    end

    // S2: fine shift by the low count bits, then clear over-shifted groups and error beats.
    always_comb begin
        fine_amt = '0;
        for (int j = 0; j < NLANES; j++) begin
            fine_amt[j*SH_W +: SH_W] = SH_W'(s1_fine_q[j*FINE_W +: FINE_W]);
        end
        s2_shift   = grp_shift(s1_data_q, s1_mode_q, fine_amt);
        out_data_d = s2_shift;
        for (int j = 0; j < NLANES; j++) begin
            if (s1_zero_q[j]) begin
                out_data_d[j*LANE_MIN +: LANE_MIN] = '0;
            end
        end
        if (s1_err_q) begin
            out_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= '0;
            s1_zero_q   <= '0;
            s1_fine_q   <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1_data_q <= s1_data_d;
                s1_mode_q <= s1_mode_d;
                s1_zero_q <= s1_zero_d;
                s1_fine_q <= s1_fine_d;
                s1_err_q  <= s1_err_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                out_data_q <= out_data_d;
                out_zero_q <= s1_zero_q;
                out_err_q  <= s1_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_simd_left_shifter_pipe.sv
// Scoreboard bench for simd_left_shifter_pipe: directed beats push hand-computed results,
// a negedge monitor pops and compares every output transfer and checks stall stability.
module tb_simd_left_shifter_pipe;
  localparam int WIDTH = 32;
  localparam int NLANES = 4;
  localparam int CNT_W = 5;
  localparam int EW = WIDTH + NLANES + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_mode = 2'd0;
  logic [WIDTH-1:0] in_data = '0;
  logic [NLANES*CNT_W-1:0] in_cnt = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [NLANES-1:0] out_zero;
  logic out_err;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  logic [EW-1:0] exp_q[$];

  simd_left_shifter_pipe #(.WIDTH(32), .LANE_MIN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NLANES*CNT_W-1:0] pack_cnt(input int c0, input int c1,
                                                       input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  // driver: hold the beat until accepted, push expected result on acceptance
  task automatic send(input logic [1:0] mode, input logic [WIDTH-1:0] data,
                      input logic [NLANES*CNT_W-1:0] cnt, input logic [WIDTH-1:0] e_data,
                      input logic [NLANES-1:0] e_zero, input logic e_err);
    int waitc = 0;
    in_mode = mode;
    in_data = data;
    in_cnt = cnt;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 50 cycles");
    end else begin
      exp_q.push_back({e_err, e_zero, e_data});
      @(posedge clk);
      accepted++;
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  logic stall_q = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [NLANES-1:0] held_zero;
  logic held_err;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_data", out_data, held_data);
        check("hold_zero", out_zero, held_zero);
        check("hold_err", out_err, held_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out_data=%0h required no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[WIDTH-1:0]);
          check("out_zero", out_zero, e[WIDTH+NLANES-1:WIDTH]);
          check("out_err", out_err, e[EW-1]);
        end
      end
      stall_q = out_valid && !out_ready;
      held_data = out_data;
      held_zero = out_zero;
      held_err = out_err;
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_zero", out_zero, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // basic mode 0 with latency measurement
    send(2'd0, 32'h81420FFF, pack_cnt(0, 1, 2, 3), 32'h10103CFE, 4'h0, 1'b0);
    lat = 0;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'd2);
    drain();

    // mode 1: upper counts of each group ignored
    send(2'd1, 32'h12348001, pack_cnt(3, 31, 0, 31), 32'h24680010, 4'h0, 1'b0);
    // mode 2 in-range, boundary s = G-1, and s >= G
    send(2'd2, 32'h00000001, pack_cnt(7, 31, 31, 31), 32'h00000100, 4'h0, 1'b0);
    send(2'd2, 32'h00000001, pack_cnt(30, 0, 0, 0), 32'h80000000, 4'h0, 1'b0);
    send(2'd2, 32'h00000001, pack_cnt(31, 0, 0, 0), 32'h00000000, 4'hF, 1'b0);
    // mode 0 single lane over-shift
    send(2'd0, 32'h11223344, pack_cnt(0, 7, 1, 2), 32'h88880088, 4'b0010, 1'b0);
    // mode 1: group 0 at s = 15, group 1 at s = 16
    send(2'd1, 32'hFFFFFFFF, pack_cnt(14, 0, 15, 0), 32'h00008000, 4'b1100, 1'b0);
    // illegal mode then recovery
    send(2'd3, 32'hDEADBEEF, pack_cnt(1, 2, 3, 4), 32'h00000000, 4'h0, 1'b1);
    send(2'd0, 32'h81420FFF, pack_cnt(0, 1, 2, 3), 32'h10103CFE, 4'h0, 1'b0);
    drain();

    // backpressure: three back-to-back beats against a stalled output
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(2'd0, 32'h01020304, pack_cnt(0, 0, 0, 0), 32'h02040608, 4'h0, 1'b0);
        send(2'd0, 32'h10203040, pack_cnt(0, 0, 0, 0), 32'h20406080, 4'h0, 1'b0);
        send(2'd0, 32'h7F7F7F7F, pack_cnt(0, 0, 0, 0), 32'hFEFEFEFE, 4'h0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_accepted", 64'(accepted), 64'd2);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(2'd0, 32'h01020304, pack_cnt(0, 0, 0, 0), 32'h02040608, 4'h0, 1'b0);
    send(2'd0, 32'h10203040, pack_cnt(0, 0, 0, 0), 32'h20406080, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_data", out_data, 32'h0);
    check("async_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(2'd1, 32'h12348001, pack_cnt(3, 31, 0, 31), 32'h24680010, 4'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
